// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter (request-to-send,
//               bit-serial on device clock falls, ACK check, timeout).
//               Optional macro PS2_HOST_TX_RETRY_EN: up to 2 automatic retries.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int CLK_HZ         = 12000000,
    parameter int INHIBIT_US     = 100,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int c_inhibit_cycles = CLK_HZ / 1000000 * INHIBIT_US;
    localparam int c_cnt_max = (c_inhibit_cycles > TIMEOUT_CYCLES) ? c_inhibit_cycles : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(c_inhibit_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_inhibit = 3'd1;
    localparam logic [2:0] c_st_rts     = 3'd2;
    localparam logic [2:0] c_st_data    = 3'd3;
    localparam logic [2:0] c_st_ack     = 3'd4;
    localparam logic [2:0] c_st_wait    = 3'd5;

    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [2:0]         r_clk_sh;
    logic               r_clk_f, r_clk_f_d;
    logic               w_fall;

    logic [2:0]         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [8:0]         r_shift, w_shift_nxt;
    logic [3:0]         r_bitcnt, w_bitcnt_nxt;
    logic               r_ok, w_ok_nxt;
    logic               r_clk_oe, w_clk_oe_nxt;
    logic               r_data_oe, w_data_oe_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic               w_fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]         r_retry, w_retry_nxt;
    logic [7:0]         r_byte, w_byte_nxt;
`endif

    // Pads are asynchronous; CLK also gets a 3-sample glitch filter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_sh  <= 3'b111;
            r_clk_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
        end else begin
            r_clk_s1  <= ps2clk_in;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2data_in;
            r_dat_s2  <= r_dat_s1;
            r_clk_sh  <= {r_clk_sh[1:0], r_clk_s2};
            if (&r_clk_sh)
                r_clk_f <= 1'b1;
            else if (~|r_clk_sh)
                r_clk_f <= 1'b0;
            r_clk_f_d <= r_clk_f;
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_ok_nxt      = r_ok;
        w_clk_oe_nxt  = r_clk_oe;
        w_data_oe_nxt = r_data_oe;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_error_nxt   = 1'b0;
        w_fail        = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        w_retry_nxt   = r_retry;
        w_byte_nxt    = r_byte;
`endif
        // Device-clock watchdog for every state after the inhibit phase
        if (r_state == c_st_rts || r_state == c_st_data ||
            r_state == c_st_ack || r_state == c_st_wait) begin
            if (w_fall)
                w_cnt_nxt = '0;
            else if (r_cnt == c_to_last)
                w_fail = 1'b1;
            else
                w_cnt_nxt = r_cnt + 1'b1;
        end

        case (r_state)
            c_st_idle: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (tx_start && !r_done && !r_error) begin
                    w_state_nxt  = c_st_inhibit;
                    w_cnt_nxt    = '0;
                    w_shift_nxt  = {~^tx_data, tx_data};
                    w_clk_oe_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
                    w_retry_nxt  = 2'd0;
                    w_byte_nxt   = tx_data;
`endif
                end
            end
            c_st_inhibit: begin
                if (r_cnt == c_inh_last) begin
                    w_cnt_nxt     = '0;
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = c_st_rts;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_rts: begin
                w_clk_oe_nxt = 1'b0;
                w_bitcnt_nxt = 4'd0;
                w_state_nxt  = c_st_data;
            end
            c_st_data: begin
                if (w_fall) begin
                    if (r_bitcnt == 4'd9) begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = c_st_ack;
                    end else begin
                        w_data_oe_nxt = ~r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[8:1]};
                        w_bitcnt_nxt  = r_bitcnt + 4'd1;
                    end
                end
            end
            c_st_ack: begin
                if (w_fall) begin
                    w_ok_nxt    = ~r_dat_s2;
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_clk_f && r_dat_s2) begin
                    if (r_ok) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase

        if (w_fail) begin
            w_done_nxt    = 1'b0;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_error_nxt   = 1'b1;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = c_st_idle;
`ifdef PS2_HOST_TX_RETRY_EN
            if (r_retry != 2'd2) begin
                w_retry_nxt  = r_retry + 2'd1;
                w_error_nxt  = 1'b0;
                w_busy_nxt   = 1'b1;
                w_clk_oe_nxt = 1'b1;
                w_cnt_nxt    = '0;
                w_shift_nxt  = {~^r_byte, r_byte};
                w_state_nxt  = c_st_inhibit;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_ok      <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry   <= 2'd0;
            r_byte    <= 8'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_ok      <= w_ok_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry   <= w_retry_nxt;
            r_byte    <= w_byte_nxt;
`endif
        end
    end

    assign ps2clk_oe  = r_clk_oe;
    assign ps2data_oe = r_data_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending side of the PS/2 link that the existing keyboard and mouse receivers only listen on.
- Sends one command byte to a PS/2 device, for example keyboard LED set (0xED) or mouse enable (0xF4), using the standard request-to-send sequence.
- Drives the open-collector CLK and DATA lines through output-enable pins; the pads pull a line low when its enable is 1.
- Sits beside the ps2 and ps2_mouse receivers, and shares their pads through the top-level inout wiring.

Parameters:
- CLK_HZ, 12000000, frequency of clk in Hz.
- INHIBIT_US, 100, time the host holds CLK low before the start bit, in µs.
- TIMEOUT_CYCLES, 24000, maximum clk cycles between device CLK falling edges (2 ms at 12 MHz).

Ports:
- clk  in  1  system clock (clk12 domain).
- rst  in  1  synchronous reset, active-high.
- ps2clk_in  in  1  raw PS/2 CLK pad level (asynchronous).
- ps2data_in  in  1  raw PS/2 DATA pad level (asynchronous).
- ps2clk_oe  out  1  1 = pull CLK low.
- ps2data_oe  out  1  1 = pull DATA low.
- tx_data  in  8  byte to send.
- tx_start  in  1  one-cycle request; tx_data is sampled on the same cycle.
- busy  out  1  high from acceptance of a request until return to IDLE.
- done  out  1  one-cycle pulse: byte acknowledged by the device.
- error  out  1  one-cycle pulse: NACK or timeout.

Behaviour:
- Reset values: ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0, state=IDLE. Reset is synchronous; asserting rst mid-transfer releases both lines at the next clk edge, with no done or error pulse.
- Input conditioning:
  - Both pads pass through a 2-FF synchroniser.
  - CLK then needs 3 consecutive equal samples to change its filtered value.
  - fall = filtered CLK goes 1→0.
- Request handling:
  - tx_start is accepted only in IDLE.
  - tx_start while busy is ignored.
  - busy rises the cycle after acceptance.
- Latched data:
  - shift register is loaded with {parity, tx_data} at acceptance.
  - parity = ~^tx_data (odd parity).
- States:
  - IDLE: all outputs low. On tx_start go to INHIBIT and clear the counter.
  - INHIBIT: ps2clk_oe=1. After INHIBIT_CYCLES = CLK_HZ/1000000*INHIBIT_US cycles (1200 at defaults), set ps2data_oe=1 (start bit 0) and go to RTS.
  - RTS: ps2data_oe=1 held. Release CLK one cycle later (ps2clk_oe=0), then go to DATA with bitcnt=0.
  - DATA:
    - On each fall, drive the next bit: ps2data_oe = ~bit. Bits go LSB first, bits 0..7, then parity (bitcnt 8).
    - On the 10th fall, release DATA (stop bit, ps2data_oe=0) and go to ACK.
  - ACK: on the next fall (11th), sample synchronised DATA.
    - 0 → acknowledged, latch ok=1.
    - 1 → latch ok=0.
    - Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered CLK=1 and DATA=1 for 1 cycle. Then pulse done if ok, else pulse error. Return to IDLE; busy falls the same cycle.
- Timeout:
  - A cycle counter runs in RTS, DATA, ACK and WAIT_IDLE, and clears on every fall.
  - When it reaches TIMEOUT_CYCLES: pulse error, release both lines, go to IDLE.
- Data is changed only on falling edges of the device clock; the device samples on rising edges.
- done and error are mutually exclusive and never high in IDLE except for their single pulse cycle.
- A tx_start arriving in the same cycle as a done or error pulse is ignored. A new request is accepted from the following cycle.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- When defined:
  - A NACK or timeout does not pulse error immediately. The block restarts from INHIBIT with the same latched byte, up to 2 retries (3 attempts total).
  - error pulses only after the third failure.
  - busy stays high across retries.
  - A 2-bit retry counter clears on acceptance.
- When undefined: the first failure pulses error; there is no retry logic and no retry counter.

Test Plan:
- Send 0xED with a device model that ACKs → bits observed on rising edges:
  - start 0;
  - data 1,0,1,1,0,1,1,1 (LSB first);
  - parity 1;
  - stop 1.
  - Then one done pulse, error=0. Also check ps2clk_oe low time = 1200±1 cycles.
- Send 0x01 → parity bit 0; send 0x00 → parity bit 1; both end in done.
- Device drives DATA high in the ack slot (NACK), macro undefined → one error pulse and no done; both oe=0 afterwards.
- Device stops clocking after 4 falls → error exactly TIMEOUT_CYCLES (24000) cycles after the 4th fall; lines released. With PS2_HOST_TX_RETRY_EN defined, three complete INHIBIT phases occur before the single error.
- Assert rst during DATA at bitcnt=5 → next cycle ps2clk_oe=0, ps2data_oe=0, busy=0, no done or error; a following 0xF4 request completes with done.
- tx_start pulsed again while busy with 0xAA → ignored; the transmitted byte stays the original 0xED.
